pixel_xor_engine: RTL
=====================

PIXEL_XOR_ENGINE -- requirements
Module: pixel_xor_engine

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning the number of colour channels processed in parallel.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the bits per channel sample.
REQ-003 The block SHALL have parameter DEPTH, default 16384, meaning the maximum pixels per frame; ADDR_W = clog2(DEPTH) is derived.
REQ-004 The block SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous and active-high.
REQ-005 The block SHALL have ports: start in 1 frame start pulse; abort in 1 stop request; len in ADDR_W+1 pixel count; dir in 1 (0 encrypt, 1 decrypt).
REQ-006 The block SHALL have ports: key_valid in 1; key_data in NUM_CH*DATA_W keystream, channel 0 in the LSBs; key_ready out 1.
REQ-007 The block SHALL have ports: rd_en out 1; rd_addr out ADDR_W; rd_data in NUM_CH*DATA_W source pixel, valid one cycle after rd_en.
REQ-008 The block SHALL have ports: wr_en out 1; wr_addr out ADDR_W; wr_data out NUM_CH*DATA_W result pixel.
REQ-009 The block SHALL have ports: busy out 1; done out 1, a level held until the next accepted start.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, XFORM and FINISH.
REQ-011 IDLE SHALL accept start only when busy=0, latch min(len, DEPTH) as the count, clear addr and done, and go to FETCH; if the latched count is 0, it SHALL go to FINISH instead.
REQ-012 FETCH SHALL assert rd_en for one cycle with rd_addr=addr, then go to XFORM.
REQ-013 XFORM SHALL capture rd_data on entry and hold it until a key is consumed.
REQ-014 XFORM SHALL drive key_ready=1 in every XFORM cycle and SHALL consume the key only on the cycle where key_valid and key_ready are both high.
REQ-015 On the consuming cycle, the block SHALL assert wr_en for one cycle, with wr_addr=addr and wr_data[c]=rd_data[c]^key_data[c] for each channel c (modulo DATA_W, no carries).
REQ-016 After a write, addr=count-1 SHALL go to FINISH; otherwise addr SHALL increment by 1 and the FSM SHALL go to FETCH.
REQ-017 Throughput SHALL be 1 pixel per 2 cycles when key_valid is held high; each cycle key_valid is low SHALL add one stall cycle with no write.
REQ-018 FINISH SHALL set done=1 and go to IDLE in the next cycle.
REQ-019 busy SHALL be 1 in FETCH, XFORM and FINISH, and 0 in IDLE.
REQ-020 abort SHALL take priority over all state activity: the FSM SHALL go to IDLE the next cycle with no write that cycle, done unchanged at 0, and key_ready=0.
REQ-021 start asserted while busy SHALL be ignored.
REQ-022 The last address used SHALL be count-1; addr SHALL never wrap past DEPTH-1.
REQ-023 key_ready, rd_en and wr_en SHALL be 0 in IDLE and FINISH.

Reset
REQ-024 rst SHALL force IDLE, addr=0, count=0, and busy, done, key_ready, rd_en and wr_en all 0.
REQ-025 rd_addr, wr_addr and wr_data SHALL reset to 0, and any chain registers SHALL reset to 0.
REQ-026 rst asserted mid-frame SHALL discard the frame with no further write; rst SHALL have priority over start and abort.

Configuration
REQ-027 Defining PIXEL_XOR_ENGINE_CHAIN_EN SHALL enable per-channel chaining with a register prev[c], which SHALL be cleared to 0 on each accepted start.
REQ-028 With chaining enabled, encrypt SHALL give out = in^key^prev, then prev<=out.
REQ-029 With chaining enabled, decrypt SHALL give out = in^key^prev, then prev<=in.
REQ-030 Without the macro, the block SHALL produce plain XOR output, ignore dir, and instantiate no chain registers.

Structure
REQ-031 Package pixel_xor_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-032 Sub-module pixel_xor_lane (one DATA_W channel: XOR plus optional chain register) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-033 Bench SHALL cover: defaults, len=4, pixels 0x102030 / 0x405060 / 0x708090 / 0xA0B0C0, key=0xFFFFFF always valid -> 4 writes of the bitwise inverses at addr 0..3, done=1 on cycle 10 after start.
REQ-034 Bench SHALL cover: key_valid low for 3 cycles during pixel 1 -> exactly 3 extra stall cycles, no duplicate or missing writes, and data unchanged.
REQ-035 Bench SHALL cover: len=0 -> no rd_en/wr_en and done=1 two cycles after start; len=20000 with DEPTH=16384 -> last wr_addr=16383.
REQ-036 Bench SHALL cover: abort asserted at pixel 2 of 8, and separately rst asserted at pixel 5 -> no further writes, busy=0 and done=0 the next cycle, and a subsequent start completes normally.
REQ-037 Bench SHALL cover, with PIXEL_XOR_ENGINE_CHAIN_EN: encrypt 16 random pixels, then decrypt the output with the same keystream -> output equals the original; first output = in^key since prev=0.

Source files
------------

// File: rtl/pixel_xor_pkg.sv
// Shared FSM state type and default sizing for the pixel XOR engine.
package pixel_xor_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16384;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    XFORM  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_xor_if.sv
// Keystream handshake plus pixel-memory read/write bus of the pixel XOR engine.
interface pixel_xor_if #(
  parameter int NUM_CH = pixel_xor_pkg::DEF_NUM_CH,
  parameter int DATA_W = pixel_xor_pkg::DEF_DATA_W,
  parameter int ADDR_W = $clog2(pixel_xor_pkg::DEF_DEPTH)
);
  localparam int PIX_W = NUM_CH * DATA_W;

  logic              key_valid;
  logic [PIX_W-1:0]  key_data;
  logic              key_ready;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    input  key_valid, key_data, rd_data,
    output key_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output key_valid, key_data, rd_data,
    input  key_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/pixel_xor_lane.sv
// One colour channel: XOR with keystream, plus a chain register when
// PIXEL_XOR_ENGINE_CHAIN_EN is defined.
module pixel_xor_lane #(
  parameter int DATA_W = 8
) (
`ifdef PIXEL_XOR_ENGINE_CHAIN_EN
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              dir,
`endif
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] res
);

`ifdef PIXEL_XOR_ENGINE_CHAIN_EN
  logic [DATA_W-1:0] prev_reg;

  assign res = pix ^ key ^ prev_reg;

  // Encrypt chains on the ciphertext it produced, decrypt on the ciphertext it consumed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_reg <= '0;
    end else if (en) begin
      prev_reg <= dir ? pix : res;
    end
  end
`else
  assign res = pix ^ key;
`endif

endmodule

// File: rtl/pixel_xor_engine.sv
// Frame engine: fetch each pixel, XOR it with one keystream word, write it back.
// Optional chaining mode is enabled by defining PIXEL_XOR_ENGINE_CHAIN_EN.
module pixel_xor_engine
  import pixel_xor_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PIX_W  = NUM_CH * DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [ADDR_W:0]  len,
  input  logic             dir,
  pixel_xor_if.master      bus,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [PIX_W-1:0]  pix_reg, pix_next;
  logic              first_reg, first_next;
  logic              done_reg, done_next;

  logic              rd_en, key_ready, wr_en, start_acc, halt;
  logic [ADDR_W:0]   len_clamped;
  logic [PIX_W-1:0]  pix_cur, lane_res;

  assign halt        = rst | abort;
  assign len_clamped = (len > DEPTH_CNT) ? DEPTH_CNT : len;
  // Read data lands on the first XFORM cycle; afterwards the held copy is used.
  assign pix_cur     = first_reg ? bus.rd_data : pix_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      pix_reg   <= '0;
      first_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      pix_reg   <= pix_next;
      first_reg <= first_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    pix_next   = pix_reg;
    first_next = 1'b0;
    done_next  = done_reg;
    rd_en      = 1'b0;
    key_ready  = 1'b0;
    wr_en      = 1'b0;
    start_acc  = 1'b0;

    if (halt) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            start_acc  = 1'b1;
            count_next = len_clamped;
            addr_next  = '0;
            done_next  = 1'b0;
            state_next = (len_clamped == '0) ? FINISH : FETCH;
          end
        end
        FETCH: begin
          rd_en      = 1'b1;
          first_next = 1'b1;
          state_next = XFORM;
        end
        XFORM: begin
          key_ready = 1'b1;
          pix_next  = pix_cur;
          if (bus.key_valid) begin
            wr_en = 1'b1;
            if ({1'b0, addr_reg} == count_reg - CNT_ONE) begin
              state_next = FINISH;
            end else begin
              addr_next  = addr_reg + ADDR_ONE;
              state_next = FETCH;
            end
          end
        end
        FINISH: begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      pixel_xor_lane #(
        .DATA_W (DATA_W)
      ) u_lane (
`ifdef PIXEL_XOR_ENGINE_CHAIN_EN
        .clk   (clk),
        .rst   (rst),
        .clear (start_acc),
        .en    (wr_en),
        .dir   (dir),
`endif
        .pix   (pix_cur[gi*DATA_W +: DATA_W]),
        .key   (bus.key_data[gi*DATA_W +: DATA_W]),
        .res   (lane_res[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

`ifndef PIXEL_XOR_ENGINE_CHAIN_EN
  // Direction and start strobe only matter to the chain registers.
  logic unused_cfg;
  assign unused_cfg = dir ^ start_acc;
`endif

  assign bus.key_ready = key_ready;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = addr_reg;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = addr_reg;
  assign bus.wr_data   = wr_en ? lane_res : '0;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;

endmodule
